// File: rtl/op_issue_pkg.sv
// Shared RV32I encodings and sequencer state type for the op_issue slice.
package riscv_pkg;

  localparam logic [6:0] OP      = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] LUI     = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/op_issue_if.sv
// Instruction, ALU, writeback and debug signals between op_issue and its neighbours.
interface op_issue_if;

  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic        alu_alt;
  logic [31:0] alu_out;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  // slave: the issue sequencer itself
  modport slave (
    input  instr_valid, instr, alu_out, dbg_addr,
    output instr_ready, alu_funct3, alu_x, alu_y, alu_alt,
           wb_valid, wb_rd, wb_data, illegal, dbg_data
  );

  // master: instruction source, ALU and debug observer
  modport master (
    output instr_valid, instr, alu_out, dbg_addr,
    input  instr_ready, alu_funct3, alu_x, alu_y, alu_alt,
           wb_valid, wb_rd, wb_data, illegal, dbg_data
  );

endinterface

// File: rtl/op_issue_regfile.sv
// 31-entry architectural register file; x0 is hardwired to zero.
module regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  ra1,
  output logic [31:0] rd1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == 5'd0)      ? '0 : regs[ra1];
  assign rd2      = (ra2 == 5'd0)      ? '0 : regs[ra2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/op_issue.sv
// Four-cycle decode/issue sequencer for RV32I OP, OP-IMM and LUI feeding a registered ALU.
module op_issue
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  op_issue_if.slave  bus
);

  state_t      state, state_next;
  logic [31:0] instr_q;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;

  logic [31:0] rs1_val, rs2_val;

  logic        dec_legal;
  logic [31:0] dec_x, dec_y;
  logic [2:0]  dec_f3;
  logic        dec_alt;

  logic [2:0]  alu_funct3_q;
  logic [31:0] alu_x_q, alu_y_q;
  logic        alu_alt_q;
  logic        wb_valid_q, illegal_q;
  logic [4:0]  wb_rd_q;
  logic        rf_we;

  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign f3     = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign f7     = instr_q[31:25];

  assign rf_we  = (state == WB);

  regfile u_regfile (
    .clk      (clk),
    .resetn   (resetn),
    .ra1      (rs1),
    .rd1      (rs1_val),
    .ra2      (rs2),
    .rd2      (rs2_val),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data),
    .we       (rf_we),
    .wa       (rd),
    .wd       (bus.alu_out)
  );

  // Operand selection and legality; only consumed while in DECODE.
  always_comb begin
    dec_legal = 1'b0;
    dec_x     = '0;
    dec_y     = '0;
    dec_f3    = '0;
    dec_alt   = 1'b0;
    case (opcode)
      OP: begin
        dec_x     = rs1_val;
        dec_y     = rs2_val;
        dec_f3    = f3;
        dec_alt   = ((f3 == F3_ADD) || (f3 == F3_SR)) ? instr_q[30] : 1'b0;
        dec_legal = (f7 == F7_BASE) ||
                    ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      end
      OP_IMM: begin
        dec_x   = rs1_val;
        dec_y   = sext12(instr_q[31:20]);
        dec_f3  = f3;
        dec_alt = (f3 == F3_SR) ? instr_q[30] : 1'b0;
        case (f3)
          F3_SLL:  dec_legal = (f7 == F7_BASE);
          F3_SR:   dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
      end
      LUI: begin
        dec_x     = '0;
        dec_y     = {instr_q[31:12], 12'b0};
        dec_f3    = F3_ADD;
        dec_alt   = 1'b0;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.instr_valid) state_next = DECODE;
      DECODE:  state_next = dec_legal ? EXEC : IDLE;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      instr_q      <= '0;
      alu_funct3_q <= '0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
      alu_alt_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      illegal_q    <= 1'b0;
    end else begin
      wb_valid_q <= (state == EXEC);
      illegal_q  <= (state == DECODE) && !dec_legal;
      if ((state == IDLE) && bus.instr_valid) begin
        instr_q <= bus.instr;
      end
      // ALU operands stay untouched on an illegal decode
      if ((state == DECODE) && dec_legal) begin
        alu_funct3_q <= dec_f3;
        alu_x_q      <= dec_x;
        alu_y_q      <= dec_y;
        alu_alt_q    <= dec_alt;
      end
      if (state == EXEC) begin
        wb_rd_q <= rd;
      end
    end
  end

  assign bus.instr_ready = resetn && (state == IDLE);
  assign bus.alu_funct3  = alu_funct3_q;
  assign bus.alu_x       = alu_x_q;
  assign bus.alu_y       = alu_y_q;
  assign bus.alu_alt     = alu_alt_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_valid_q ? bus.alu_out : '0;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_op_issue.sv
// Self-checking bench for op_issue with a registered ALU model and writeback scoreboard.
module tb_op_issue;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  op_issue_if bus ();

  op_issue dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  // Registered ALU standing in for the downstream alu block
  always @(posedge clk) begin
    if (!resetn) begin
      bus.alu_out <= '0;
    end else begin
      case (bus.alu_funct3)
        3'b000: bus.alu_out <= bus.alu_alt ? bus.alu_x - bus.alu_y : bus.alu_x + bus.alu_y;
        3'b001: bus.alu_out <= bus.alu_x << bus.alu_y[4:0];
        3'b010: bus.alu_out <= {31'b0, $signed(bus.alu_x) < $signed(bus.alu_y)};
        3'b011: bus.alu_out <= {31'b0, bus.alu_x < bus.alu_y};
        3'b100: bus.alu_out <= bus.alu_x ^ bus.alu_y;
        3'b101: bus.alu_out <= bus.alu_alt ? 32'($signed(bus.alu_x) >>> bus.alu_y[4:0])
                                           : bus.alu_x >> bus.alu_y[4:0];
        3'b110: bus.alu_out <= bus.alu_x | bus.alu_y;
        default: bus.alu_out <= bus.alu_x & bus.alu_y;
      endcase
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OP_IMM};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, LUI};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int w = 0;
    while (!bus.instr_ready && w < 20) begin
      step();
      w++;
    end
    n_chk++;
    if (bus.instr_ready !== 1'b1)
      $display("FAIL %s ready_wait: instr_ready=%b after %0d cycles, expected 1", nm, bus.instr_ready, w);
    else n_pass++;
  endtask

  task automatic read_reg(input logic [4:0] a, input logic [31:0] exp, input string nm);
    bus.dbg_addr = a;
    #1;
    n_chk++;
    if (bus.dbg_data !== exp)
      $display("FAIL %s dbg x%0d: got %h expected %h", nm, a, bus.dbg_data, exp);
    else n_pass++;
  endtask

  // Issue one legal instruction and check its writeback against the scoreboard
  task automatic issue(input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] data,
                       input bit chk_alt, input logic exp_alt, input string nm);
    int  cyc;
    bit  seen;
    bit  ready_hi;
    wb_t e;
    wait_ready(nm);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    sb.push_back('{rd, data});
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
    cyc = 1; seen = 1'b0; ready_hi = 1'b0;
    while (cyc <= 6 && !seen) begin
      if (bus.instr_ready) ready_hi = 1'b1;
      if (bus.wb_valid) seen = 1'b1;
      else begin
        if (cyc == 2 && chk_alt) begin
          n_chk++;
          if (bus.alu_alt !== exp_alt)
            $display("FAIL %s exec_alt: got %b expected %b", nm, bus.alu_alt, exp_alt);
          else n_pass++;
        end
        step();
        cyc++;
      end
    end
    n_chk++;
    if (!seen || cyc != 3)
      $display("FAIL %s wb_latency: got %0d (seen=%0d) expected 3 cycles", nm, cyc, seen);
    else n_pass++;
    n_chk++;
    if (ready_hi)
      $display("FAIL %s ready_busy: instr_ready went 1 expected 0 before writeback", nm);
    else n_pass++;
    e = sb.pop_front();
    if (seen) begin
      n_chk++;
      if (bus.wb_rd !== e.rd)
        $display("FAIL %s wb_rd: got %0d expected %0d", nm, bus.wb_rd, e.rd);
      else n_pass++;
      n_chk++;
      if (bus.wb_data !== e.data)
        $display("FAIL %s wb_data: got %h expected %h", nm, bus.wb_data, e.data);
      else n_pass++;
    end
    step();
    n_chk++;
    if (bus.instr_ready !== 1'b1 || bus.wb_valid !== 1'b0)
      $display("FAIL %s post_wb: ready=%b wb_valid=%b expected 1/0", nm, bus.instr_ready, bus.wb_valid);
    else n_pass++;
  endtask

  task automatic issue_illegal(input logic [31:0] ins, input string nm);
    logic [67:0] alu_before;
    wait_ready(nm);
    alu_before = {bus.alu_alt, bus.alu_funct3, bus.alu_x, bus.alu_y};
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    step();
    bus.instr_valid = 1'b0;
    n_chk++;
    if (bus.illegal !== 1'b0 || bus.wb_valid !== 1'b0)
      $display("FAIL %s cyc1: illegal=%b wb_valid=%b expected 0/0", nm, bus.illegal, bus.wb_valid);
    else n_pass++;
    step();
    n_chk++;
    if (bus.illegal !== 1'b1 || bus.instr_ready !== 1'b1 || bus.wb_valid !== 1'b0)
      $display("FAIL %s cyc2: illegal=%b ready=%b wb_valid=%b expected 1/1/0",
               nm, bus.illegal, bus.instr_ready, bus.wb_valid);
    else n_pass++;
    n_chk++;
    if ({bus.alu_alt, bus.alu_funct3, bus.alu_x, bus.alu_y} !== alu_before)
      $display("FAIL %s alu_hold: got %h expected %h", nm,
               {bus.alu_alt, bus.alu_funct3, bus.alu_x, bus.alu_y}, alu_before);
    else n_pass++;
    step();
    n_chk++;
    if (bus.illegal !== 1'b0 || bus.wb_valid !== 1'b0)
      $display("FAIL %s cyc3: illegal=%b wb_valid=%b expected 0/0", nm, bus.illegal, bus.wb_valid);
    else n_pass++;
  endtask

  task automatic check_outputs_zero(input string nm);
    n_chk++;
    if ({bus.alu_funct3, bus.alu_x, bus.alu_y, bus.alu_alt, bus.wb_valid, bus.wb_rd, bus.illegal} !== '0)
      $display("FAIL %s outputs_zero: f3=%h x=%h y=%h alt=%b wbv=%b rd=%0d ill=%b expected all 0",
               nm, bus.alu_funct3, bus.alu_x, bus.alu_y, bus.alu_alt, bus.wb_valid, bus.wb_rd, bus.illegal);
    else n_pass++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    n_chk++;
    if (bus.instr_ready !== 1'b0)
      $display("FAIL reset ready_low: got %b expected 0", bus.instr_ready);
    else n_pass++;
    check_outputs_zero("reset");
    resetn = 1'b1;
    step();
    n_chk++;
    if (bus.instr_ready !== 1'b1)
      $display("FAIL reset ready_high: got %b expected 1", bus.instr_ready);
    else n_pass++;
    for (int r = 0; r < 32; r += 5) read_reg(5'(r), 32'h0, "reset");
  endtask

  task automatic test_add_chain();
    issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1), 5'd1, 32'd5, 1'b0, 1'b0, "addi_x1");
    issue(enc_r(F7_BASE, 5'd1, 5'd1, 3'b000, 5'd2), 5'd2, 32'd10, 1'b1, 1'b0, "add_x2");
    read_reg(5'd2, 32'd10, "add_chain");
  endtask

  task automatic test_shift_lui();
    issue(enc_u(20'h80000, 5'd3), 5'd3, 32'h8000_0000, 1'b1, 1'b0, "lui_x3");
    issue(enc_i({F7_ALT, 5'd4}, 5'd3, 3'b101, 5'd4), 5'd4, 32'hF800_0000, 1'b1, 1'b1, "srai_x4");
    issue(enc_i({F7_BASE, 5'd4}, 5'd3, 3'b101, 5'd5), 5'd5, 32'h0800_0000, 1'b1, 1'b0, "srli_x5");
    read_reg(5'd3, 32'h8000_0000, "shift");
    read_reg(5'd4, 32'hF800_0000, "shift");
  endtask

  task automatic test_sign_ext();
    issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd6), 5'd6, 32'hFFFF_FFFF, 1'b1, 1'b0, "addi_neg");
    issue(enc_r(F7_ALT, 5'd6, 5'd0, 3'b000, 5'd7), 5'd7, 32'd1, 1'b1, 1'b1, "sub_x7");
    read_reg(5'd6, 32'hFFFF_FFFF, "sign_ext");
    read_reg(5'd7, 32'd1, "sign_ext");
  endtask

  task automatic test_x0_write();
    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd0), 5'd0, 32'd7, 1'b0, 1'b0, "addi_x0");
    read_reg(5'd0, 32'h0, "x0_write");
  endtask

  task automatic test_illegal();
    logic [31:0] br;
    br = {7'b0, 5'd1, 5'd2, 3'b000, 5'd9, 7'b1100011};
    issue_illegal(br, "ill_opcode");
    issue_illegal(enc_r(F7_ALT, 5'd1, 5'd1, 3'b001, 5'd9), "ill_sll_alt");
    issue_illegal(enc_i({F7_ALT, 5'd3}, 5'd1, 3'b001, 5'd9), "ill_slli_alt");
    read_reg(5'd9, 32'h0, "illegal");
    read_reg(5'd1, 32'd5, "illegal");
    read_reg(5'd5, 32'h0800_0000, "illegal");
  endtask

  task automatic test_mid_reset();
    bit wb_seen = 1'b0;
    wait_ready("mid_reset");
    bus.instr_valid = 1'b1;
    bus.instr       = enc_i(12'd9, 5'd0, 3'b000, 5'd8);
    step();
    bus.instr_valid = 1'b0;
    step();
    n_chk++;
    if (bus.alu_y !== 32'd9)
      $display("FAIL mid_reset exec_y: got %h expected %h", bus.alu_y, 32'd9);
    else n_pass++;
    resetn = 1'b0;
    step();
    if (bus.wb_valid) wb_seen = 1'b1;
    n_chk++;
    if (bus.instr_ready !== 1'b0)
      $display("FAIL mid_reset ready_low: got %b expected 0", bus.instr_ready);
    else n_pass++;
    check_outputs_zero("mid_reset");
    step();
    if (bus.wb_valid) wb_seen = 1'b1;
    resetn = 1'b1;
    step();
    if (bus.wb_valid) wb_seen = 1'b1;
    n_chk++;
    if (wb_seen || bus.instr_ready !== 1'b1)
      $display("FAIL mid_reset recover: wb_seen=%0d ready=%b expected 0/1", wb_seen, bus.instr_ready);
    else n_pass++;
    read_reg(5'd8, 32'h0, "mid_reset");
    read_reg(5'd1, 32'h0, "mid_reset");
    issue(enc_i(12'd3, 5'd0, 3'b000, 5'd8), 5'd8, 32'd3, 1'b0, 1'b0, "addi_x8");
    read_reg(5'd8, 32'd3, "mid_reset");
  endtask

  task automatic test_back_to_back();
    issue(enc_i(12'hFF0, 5'd0, 3'b000, 5'd1), 5'd1, 32'hFFFF_FFF0, 1'b0, 1'b0, "b2b_addi");
    issue(enc_i(12'h0FF, 5'd1, 3'b100, 5'd2), 5'd2, 32'hFFFF_FF0F, 1'b0, 1'b0, "b2b_xori");
    issue(enc_i(12'h123, 5'd0, 3'b110, 5'd3), 5'd3, 32'h0000_0123, 1'b0, 1'b0, "b2b_ori");
    issue(enc_r(F7_BASE, 5'd3, 5'd1, 3'b111, 5'd4), 5'd4, 32'h0000_0120, 1'b0, 1'b0, "b2b_and");
    issue(enc_r(F7_BASE, 5'd1, 5'd3, 3'b011, 5'd5), 5'd5, 32'd1, 1'b0, 1'b0, "b2b_sltu");
    issue(enc_r(F7_BASE, 5'd3, 5'd1, 3'b010, 5'd6), 5'd6, 32'd1, 1'b0, 1'b0, "b2b_slt");
    issue(enc_i({F7_BASE, 5'd4}, 5'd3, 3'b001, 5'd7), 5'd7, 32'h0000_1230, 1'b0, 1'b0, "b2b_slli");
    read_reg(5'd7, 32'h0000_1230, "b2b");
    n_chk++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.dbg_addr    = '0;
    test_reset();
    test_add_chain();
    test_shift_lui();
    test_sign_ext();
    test_x0_write();
    test_illegal();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
